// File: rtl/execute_mem_issue_queue.sv
// execute_mem_issue_queue
//
// In-order issue queue that sits in front of the memory execute stage.
// Dispatched ops are held in a circular buffer. Each waiting source operand
// snoops the writeback bus by ROB tag. Only the oldest op (the head) may issue,
// and it issues once both of its operands are ready and the memory stage can
// take it. A younger ready op never passes a blocked head.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   bco_valid         branch-commit override: drops this cycle's dispatch and
//                     issue, and empties the queue at the next edge
//   s_*               dispatch request; s_ready = queue not full
//   wb_*              writeback broadcast (tag + value)
//   mem_ready         memory stage can accept an op this cycle
//   o_*               issue port; o_valid = fire, data comes straight from the head
//
// DEPTH must be a power of two in the range 2..16, so the pointers wrap on
// their own.

module execute_mem_issue_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bco_valid,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        s_src0_ready,
   input  logic        s_src1_ready,
   input  logic [31:0] s_src0_value,
   input  logic [31:0] s_src1_value,
   input  logic [3:0]  s_src0_rob,
   input  logic [3:0]  s_src1_rob,
   input  logic [3:0]  s_dst_rob,
   input  logic [25:0] s_imm,
   input  logic [7:0]  s_fid,
   input  logic [4:0]  s_mem_cmd,
   input  logic        wb_valid,
   input  logic [3:0]  wb_rob,
   input  logic [31:0] wb_value,
   input  logic        mem_ready,
   output logic        o_valid,
   output logic [31:0] o_src0_value,
   output logic [31:0] o_src1_value,
   output logic [3:0]  o_dst_rob,
   output logic [25:0] o_imm,
   output logic [7:0]  o_fid,
   output logic [4:0]  o_mem_cmd
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic          valid_q [DEPTH];
   logic          rdy0_q  [DEPTH];
   logic          rdy1_q  [DEPTH];
   logic [31:0]   val0_q  [DEPTH];
   logic [31:0]   val1_q  [DEPTH];
   logic [3:0]    tag0_q  [DEPTH];
   logic [3:0]    tag1_q  [DEPTH];
   logic [3:0]    dst_q   [DEPTH];
   logic [25:0]   imm_q   [DEPTH];
   logic [7:0]    fid_q   [DEPTH];
   logic [4:0]    cmd_q   [DEPTH];

   logic          valid_d [DEPTH];
   logic          rdy0_d  [DEPTH];
   logic          rdy1_d  [DEPTH];
   logic [31:0]   val0_d  [DEPTH];
   logic [31:0]   val1_d  [DEPTH];
   logic [3:0]    tag0_d  [DEPTH];
   logic [3:0]    tag1_d  [DEPTH];
   logic [3:0]    dst_d   [DEPTH];
   logic [25:0]   imm_d   [DEPTH];
   logic [7:0]    fid_d   [DEPTH];
   logic [4:0]    cmd_d   [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic          push;
   logic          fire;
   logic          in_wake0, in_wake1;

   assign s_ready = (count_q < CW'(DEPTH));

   // Full means refuse, even if the head leaves this same cycle.
   assign push = s_valid & s_ready & ~bco_valid;
   assign fire = valid_q[rd_ptr_q] & rdy0_q[rd_ptr_q] & rdy1_q[rd_ptr_q]
               & mem_ready & ~bco_valid;

   // The op arriving this cycle also sees the current writeback.
   assign in_wake0 = ~s_src0_ready & wb_valid & (s_src0_rob == wb_rob);
   assign in_wake1 = ~s_src1_ready & wb_valid & (s_src1_rob == wb_rob);

   always_comb begin
      valid_d  = valid_q;
      rdy0_d   = rdy0_q;
      rdy1_d   = rdy1_q;
      val0_d   = val0_q;
      val1_d   = val1_q;
      tag0_d   = tag0_q;
      tag1_d   = tag1_q;
      dst_d    = dst_q;
      imm_d    = imm_q;
      fid_d    = fid_q;
      cmd_d    = cmd_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (bco_valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = 1'b0;
         end
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (valid_q[i] && !rdy0_q[i] && (tag0_q[i] == wb_rob)) begin
                  rdy0_d[i] = 1'b1;
                  val0_d[i] = wb_value;
               end
               if (valid_q[i] && !rdy1_q[i] && (tag1_q[i] == wb_rob)) begin
                  rdy1_d[i] = 1'b1;
                  val1_d[i] = wb_value;
               end
            end
         end

         if (fire) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
         end

         // The write slot is never the firing head: a non-full queue has an
         // empty slot at wr_ptr, and an empty queue cannot fire.
         if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            rdy0_d[wr_ptr_q]  = s_src0_ready | in_wake0;
            rdy1_d[wr_ptr_q]  = s_src1_ready | in_wake1;
            val0_d[wr_ptr_q]  = in_wake0 ? wb_value : s_src0_value;
            val1_d[wr_ptr_q]  = in_wake1 ? wb_value : s_src1_value;
            tag0_d[wr_ptr_q]  = s_src0_rob;
            tag1_d[wr_ptr_q]  = s_src1_rob;
            dst_d[wr_ptr_q]   = s_dst_rob;
            imm_d[wr_ptr_q]   = s_imm;
            fid_d[wr_ptr_q]   = s_fid;
            cmd_d[wr_ptr_q]   = s_mem_cmd;
            wr_ptr_d          = wr_ptr_q + PW'(1);
         end

         case ({push, fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            rdy0_q[i]  <= 1'b0;
            rdy1_q[i]  <= 1'b0;
            val0_q[i]  <= '0;
            val1_q[i]  <= '0;
            tag0_q[i]  <= '0;
            tag1_q[i]  <= '0;
            dst_q[i]   <= '0;
            imm_q[i]   <= '0;
            fid_q[i]   <= '0;
            cmd_q[i]   <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         rdy0_q   <= rdy0_d;
         rdy1_q   <= rdy1_d;
         val0_q   <= val0_d;
         val1_q   <= val1_d;
         tag0_q   <= tag0_d;
         tag1_q   <= tag1_d;
         dst_q    <= dst_d;
         imm_q    <= imm_d;
         fid_q    <= fid_d;
         cmd_q    <= cmd_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Head fields drive the issue port directly; only o_valid qualifies them.
   assign o_valid      = fire;
   assign o_src0_value = val0_q[rd_ptr_q];
   assign o_src1_value = val1_q[rd_ptr_q];
   assign o_dst_rob    = dst_q[rd_ptr_q];
   assign o_imm        = imm_q[rd_ptr_q];
   assign o_fid        = fid_q[rd_ptr_q];
   assign o_mem_cmd    = cmd_q[rd_ptr_q];

endmodule

// File: tb/tb_execute_mem_issue_queue.sv
// Bench for execute_mem_issue_queue: scenario tasks plus a randomized run,
// all compared against an op-level queue model of the issue queue.

module tb_execute_mem_issue_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        bco_valid = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        s_src0_ready = 1'b0, s_src1_ready = 1'b0;
   logic [31:0] s_src0_value = '0, s_src1_value = '0;
   logic [3:0]  s_src0_rob = '0, s_src1_rob = '0;
   logic [3:0]  s_dst_rob = '0;
   logic [25:0] s_imm = '0;
   logic [7:0]  s_fid = '0;
   logic [4:0]  s_mem_cmd = '0;
   logic        wb_valid = 1'b0;
   logic [3:0]  wb_rob = '0;
   logic [31:0] wb_value = '0;
   logic        mem_ready = 1'b0;
   logic        o_valid;
   logic [31:0] o_src0_value, o_src1_value;
   logic [3:0]  o_dst_rob;
   logic [25:0] o_imm;
   logic [7:0]  o_fid;
   logic [4:0]  o_mem_cmd;

   execute_mem_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bco_valid(bco_valid),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_src0_ready(s_src0_ready), .s_src1_ready(s_src1_ready),
      .s_src0_value(s_src0_value), .s_src1_value(s_src1_value),
      .s_src0_rob(s_src0_rob), .s_src1_rob(s_src1_rob),
      .s_dst_rob(s_dst_rob), .s_imm(s_imm), .s_fid(s_fid), .s_mem_cmd(s_mem_cmd),
      .wb_valid(wb_valid), .wb_rob(wb_rob), .wb_value(wb_value),
      .mem_ready(mem_ready),
      .o_valid(o_valid), .o_src0_value(o_src0_value), .o_src1_value(o_src1_value),
      .o_dst_rob(o_dst_rob), .o_imm(o_imm), .o_fid(o_fid), .o_mem_cmd(o_mem_cmd)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        r0; bit [31:0] v0; bit [3:0] t0;
      bit        r1; bit [31:0] v1; bit [3:0] t1;
      bit [3:0]  dst; bit [25:0] imm; bit [7:0] fid; bit [4:0] cmd;
   } op_t;

   op_t         mq[$];
   logic [3:0]  issued_dst[$];
   int          checks = 0;
   int          failures = 0;
   logic        exp_valid, exp_ready, obs_valid, obs_ready;
   logic [106:0] exp_data, obs_data;
   logic [31:0] obs_src0, obs_src1;
   logic [3:0]  obs_dst;

   // One clock: sample at the falling edge, then advance the model at the
   // rising edge with the same inputs the DUT sees.
   task automatic tick();
      op_t n;
      @(negedge clk);
      exp_ready = (mq.size() < DEPTH);
      exp_valid = !bco_valid && mem_ready && (mq.size() > 0) && mq[0].r0 && mq[0].r1;
      exp_data  = '0;
      if (mq.size() > 0)
         exp_data = {mq[0].v0, mq[0].v1, mq[0].dst, mq[0].imm, mq[0].fid, mq[0].cmd};
      obs_valid = o_valid;
      obs_ready = s_ready;
      obs_data  = {o_src0_value, o_src1_value, o_dst_rob, o_imm, o_fid, o_mem_cmd};
      obs_src0  = o_src0_value;
      obs_src1  = o_src1_value;
      obs_dst   = o_dst_rob;
      if (o_valid === 1'b1) issued_dst.push_back(o_dst_rob);
      @(posedge clk);
      if (bco_valid) begin
         mq.delete();
      end else begin
         if (exp_valid) void'(mq.pop_front());
         if (wb_valid) begin
            foreach (mq[i]) begin
               if (!mq[i].r0 && mq[i].t0 == wb_rob) begin mq[i].r0 = 1; mq[i].v0 = wb_value; end
               if (!mq[i].r1 && mq[i].t1 == wb_rob) begin mq[i].r1 = 1; mq[i].v1 = wb_value; end
            end
         end
         if (s_valid && exp_ready) begin
            n.r0 = s_src0_ready; n.v0 = s_src0_value; n.t0 = s_src0_rob;
            n.r1 = s_src1_ready; n.v1 = s_src1_value; n.t1 = s_src1_rob;
            if (!n.r0 && wb_valid && n.t0 == wb_rob) begin n.r0 = 1; n.v0 = wb_value; end
            if (!n.r1 && wb_valid && n.t1 == wb_rob) begin n.r1 = 1; n.v1 = wb_value; end
            n.dst = s_dst_rob; n.imm = s_imm; n.fid = s_fid; n.cmd = s_mem_cmd;
            mq.push_back(n);
         end
      end
      #1;
   endtask

   task automatic idle();
      s_valid = 0; wb_valid = 0; bco_valid = 0;
   endtask

   task automatic drive_op(input logic [3:0] dst, input logic r0, input logic [3:0] t0,
                           input logic r1, input logic [3:0] t1);
      s_valid = 1; s_dst_rob = dst;
      s_imm = 26'($urandom); s_fid = 8'($urandom); s_mem_cmd = 5'($urandom);
      s_src0_ready = r0; s_src0_value = $urandom; s_src0_rob = t0;
      s_src1_ready = r1; s_src1_value = $urandom; s_src1_rob = t1;
   endtask

   task automatic test_reset();
      reset = 1; #1;
      checks++;
      if (o_valid !== 1'b0 || s_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state o_valid=%b s_ready=%b want 0/1", o_valid, s_ready);
      end
      checks++;
      if ({o_src0_value, o_src1_value, o_dst_rob, o_imm, o_fid, o_mem_cmd} !== 107'd0) begin
         failures++;
         $display("FAIL reset_data got dst=%h imm=%h src0=%h want all 0", o_dst_rob, o_imm, o_src0_value);
      end
      @(posedge clk); #1; reset = 0; mq.delete();
   endtask

   task automatic test_in_order();
      idle(); mem_ready = 1; issued_dst.delete();
      for (int i = 0; i < 7; i++) begin
         if (i < 4) begin drive_op(4'(i + 1), 1, 0, 1, 0); s_imm = 26'h100 + 26'(i); end
         else s_valid = 0;
         tick();
         checks++;
         if (obs_valid !== exp_valid || obs_ready !== exp_ready) begin
            failures++;
            $display("FAIL in_order c%0d valid/ready got %b/%b want %b/%b", i, obs_valid, obs_ready, exp_valid, exp_ready);
         end
         if (exp_valid) begin
            checks++;
            if (obs_data !== exp_data) begin
               failures++;
               $display("FAIL in_order_data c%0d got %h want %h", i, obs_data, exp_data);
            end
         end
      end
      checks++;
      if (issued_dst.size() != 4 || issued_dst[0] != 1 || issued_dst[1] != 2 || issued_dst[2] != 3 || issued_dst[3] != 4) begin
         failures++;
         $display("FAIL in_order_seq got %0d issues want 1,2,3,4", issued_dst.size());
      end
   endtask

   task automatic test_full();
      idle(); mem_ready = 0; issued_dst.delete();
      for (int i = 0; i < 5; i++) begin
         drive_op(4'(5 + i), 1, 0, 1, 0);
         tick();
         checks++;
         if (obs_valid !== exp_valid || obs_ready !== exp_ready) begin
            failures++;
            $display("FAIL full_fill c%0d valid/ready got %b/%b want %b/%b", i, obs_valid, obs_ready, exp_valid, exp_ready);
         end
      end
      checks++;
      if (obs_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_sready got %b want 0", obs_ready);
      end
      idle(); mem_ready = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (obs_valid !== exp_valid || (exp_valid && obs_data !== exp_data)) begin
            failures++;
            $display("FAIL full_drain c%0d valid got %b want %b data %h want %h", i, obs_valid, exp_valid, obs_data, exp_data);
         end
      end
      checks++;
      if (issued_dst.size() != 4 || issued_dst[0] != 5 || issued_dst[3] != 8 || obs_ready !== 1'b1) begin
         failures++;
         $display("FAIL full_result issues=%0d s_ready=%b want 4 issues (5..8) and 1", issued_dst.size(), obs_ready);
      end
   endtask

   task automatic test_wakeup();
      idle(); mem_ready = 1;
      drive_op(4'd8, 1, 0, 0, 4'd7); tick();
      drive_op(4'd9, 1, 0, 1, 0);    tick();
      idle();                         tick();
      checks++;
      if (obs_valid !== 1'b0 || exp_valid !== 1'b0) begin
         failures++;
         $display("FAIL wake_blocked o_valid=%b model=%b want 0", obs_valid, exp_valid);
      end
      wb_valid = 1; wb_rob = 4'd7; wb_value = 32'hDEADBEEF; tick();
      checks++;
      if (obs_valid !== 1'b0) begin
         failures++;
         $display("FAIL wake_no_forward o_valid=%b want 0", obs_valid);
      end
      idle(); tick();
      checks++;
      if (obs_valid !== 1'b1 || obs_dst !== 4'd8 || obs_src1 !== 32'hDEADBEEF || obs_data !== exp_data) begin
         failures++;
         $display("FAIL wake_issue valid=%b dst=%h src1=%h want 1/8/deadbeef", obs_valid, obs_dst, obs_src1);
      end
      tick();
      checks++;
      if (obs_valid !== 1'b1 || obs_dst !== 4'd9 || obs_data !== exp_data) begin
         failures++;
         $display("FAIL wake_second valid=%b dst=%h want 1/9", obs_valid, obs_dst);
      end
   endtask

   task automatic test_same_cycle_wake();
      idle(); mem_ready = 1;
      drive_op(4'd10, 0, 4'd3, 1, 0);
      wb_valid = 1; wb_rob = 4'd3; wb_value = 32'h12345678;
      tick();
      idle(); tick();
      checks++;
      if (obs_valid !== 1'b1 || obs_dst !== 4'd10 || obs_src0 !== 32'h12345678 || obs_data !== exp_data) begin
         failures++;
         $display("FAIL same_cycle_wake valid=%b dst=%h src0=%h want 1/a/12345678", obs_valid, obs_dst, obs_src0);
      end
   endtask

   task automatic test_flush();
      idle(); mem_ready = 0;
      for (int i = 0; i < 3; i++) begin drive_op(4'(11 + i), 1, 0, 1, 0); tick(); end
      issued_dst.delete();
      drive_op(4'd14, 1, 0, 1, 0); bco_valid = 1; mem_ready = 1;
      tick();
      checks++;
      if (obs_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_ovalid got %b want 0", obs_valid);
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty c%0d s_ready=%b o_valid=%b want 1/0", i, obs_ready, obs_valid);
         end
      end
      checks++;
      if (issued_dst.size() != 0) begin
         failures++;
         $display("FAIL flush_dropped issues=%0d want 0", issued_dst.size());
      end
   endtask

   task automatic test_async_reset();
      idle(); mem_ready = 0;
      for (int i = 0; i < 2; i++) begin drive_op(4'(1 + i), 1, 0, 1, 0); tick(); end
      idle(); mem_ready = 1;
      #2 reset = 1;
      #1;
      checks++;
      if (o_valid !== 1'b0 || s_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset o_valid=%b s_ready=%b want 0/1", o_valid, s_ready);
      end
      mq.delete();
      @(posedge clk); #1 reset = 0;
      issued_dst.delete();
      for (int i = 0; i < 16; i++) begin
         if (i < 11) drive_op(4'(i), 1, 0, 1, 0); else s_valid = 0;
         mem_ready = ($urandom_range(0, 3) != 0) || (i >= 11);
         tick();
         checks++;
         if (obs_valid !== exp_valid || obs_ready !== exp_ready || (exp_valid && obs_data !== exp_data)) begin
            failures++;
            $display("FAIL wrap c%0d valid/ready got %b/%b want %b/%b data %h want %h",
                     i, obs_valid, obs_ready, exp_valid, exp_ready, obs_data, exp_data);
         end
      end
      idle(); mem_ready = 1;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (issued_dst.size() != 11) begin
         failures++;
         $display("FAIL wrap_count issues=%0d want 11", issued_dst.size());
      end else begin
         for (int i = 0; i < 11; i++) begin
            checks++;
            if (issued_dst[i] !== 4'(i)) begin
               failures++;
               $display("FAIL wrap_order idx%0d got %h want %h", i, issued_dst[i], 4'(i));
            end
         end
      end
   endtask

   task automatic test_random();
      idle();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) != 0)
            drive_op(4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom),
                     1'($urandom_range(0, 1)), 4'($urandom));
         else
            s_valid = 0;
         wb_valid  = 1'($urandom_range(0, 1));
         wb_rob    = 4'($urandom);
         wb_value  = $urandom;
         mem_ready = ($urandom_range(0, 3) != 0);
         bco_valid = ($urandom_range(0, 39) == 0);
         tick();
         checks++;
         if (obs_valid !== exp_valid || obs_ready !== exp_ready || (exp_valid && obs_data !== exp_data)) begin
            failures++;
            $display("FAIL random c%0d valid/ready got %b/%b want %b/%b data %h want %h",
                     i, obs_valid, obs_ready, exp_valid, exp_ready, obs_data, exp_data);
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_full();
      test_wakeup();
      test_same_cycle_wake();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/execute_mem_issue_queue.md
# execute_mem_issue_queue

In-order issue queue for the memory pipe. It accepts dispatched memory ops with source operands that may still be pending. It captures operand values from the writeback bus and releases the oldest op to the execute_mem input register stage once both operands are ready. It sits between dispatch and the memory execute stage, drives that stage's `i_*` inputs, and shares its `bco_valid` flush.

## Interface

Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of two, 2..16.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `bco_valid`  in  1  branch-commit override; flushes the queue
- `s_valid`  in  1  dispatch request
- `s_ready`  out  1  queue can accept an op (not full)
- `s_src0_ready` / `s_src1_ready`  in  1  operand value already available
- `s_src0_value` / `s_src1_value`  in  32  operand value, meaningful when ready
- `s_src0_rob` / `s_src1_rob`  in  4  producer ROB tag, meaningful when not ready
- `s_dst_rob`  in  4,  `s_imm`  in  26,  `s_fid`  in  8,  `s_mem_cmd`  in  5
- `wb_valid`  in  1,  `wb_rob`  in  4,  `wb_value`  in  32: writeback broadcast
- `mem_ready`  in  1  memory stage can take an op this cycle
- `o_valid`  out  1,  `o_src0_value` / `o_src1_value`  out  32,  `o_dst_rob`  out  4,  `o_imm`  out  26,  `o_fid`  out  8,  `o_mem_cmd`  out  5: issue port to the memory stage input registers

## Operation

- Circular buffer with `DEPTH` entries, a read pointer, a write pointer and an occupancy count of width log2(DEPTH)+1. Pointers wrap modulo `DEPTH`.
- Each entry holds: valid, two operands (ready bit, 32-bit value, 4-bit tag), dst_rob, imm, fid, mem_cmd.
- Dispatch: `s_valid & s_ready & ~bco_valid` writes the entry at the write pointer and advances the pointer.
- Wakeup:
  - Every valid entry with an operand where ready=0 and tag==`wb_rob` captures `wb_value` and sets ready when `wb_valid`.
  - The entry being dispatched in the same cycle is woken the same way: a not-ready `s_srcN` whose tag matches the asserted `wb_rob` is stored as ready with `wb_value`.
  - Already-ready operands ignore `wb`.
- Issue is strictly in order, from the head only.
  - fire = head valid & both head operands ready & `mem_ready` & ~`bco_valid`.
  - On fire the head is invalidated and the read pointer advances.
  - A younger ready op never bypasses a blocked head.
- Outputs are combinational from the head entry. `o_valid` = fire. Data outputs always reflect the head fields (don't-care when `o_valid`=0).
- `s_ready` = count < `DEPTH`. There is no same-cycle pass-through, so a full queue refuses dispatch even if it fires that cycle.
- `bco_valid`:
  - Next edge: all entries invalid, pointers 0, count 0.
  - That cycle: dispatch is dropped, `o_valid`=0, and no wakeup matters.
- Count update: +1 on dispatch, −1 on fire, unchanged when both happen.

## Timing

- Reset (async assert, deasserted synchronously by the environment): all entries invalid, pointers and count 0. So `s_ready`=1 and `o_valid`=0 immediately on assertion. Data outputs reset to 0.
- Dispatch-to-issue latency for an op with both operands ready into an empty queue: 1 cycle. It is written at edge N and `o_valid` is high in cycle N+1 if `mem_ready`.
- Wakeup latency: `wb` in cycle N makes the operand ready from cycle N+1. The op can issue in N+1, with the captured value on the outputs.
- Operands do not forward combinationally from `wb` to the outputs in the same cycle.
- Reset mid-operation discards all entries with no issue.
- `bco_valid` has priority over dispatch, wakeup and issue.

## Test plan

- Reset, then dispatch 4 ready ops (dst_rob 1..4, imm 0x100..0x103) with `mem_ready`=1 -> `o_valid` in 4 consecutive cycles starting one cycle after the first dispatch, in order, with matching fields. `s_ready` stays 1.
- `mem_ready`=0, dispatch 4 ops (`DEPTH`=4) -> `s_ready`=0 after the 4th. A 5th `s_valid` is not accepted. Release `mem_ready` -> 4 issues in order, then `s_ready`=1.
- Head src1 waits on tag 7 while the second entry is fully ready -> no issue. `wb_valid`, `wb_rob`=7, `wb_value`=0xDEADBEEF -> next cycle head issues with `o_src1_value`=0xDEADBEEF, then the second entry follows.
- Dispatch an op whose src0 waits on tag 3 in the same cycle as `wb_rob`=3, `wb_value`=0x12345678 -> it issues the next cycle with `o_src0_value`=0x12345678.
- 3 entries queued plus a dispatch in the same cycle as `bco_valid` -> `o_valid`=0 that cycle, queue empty next cycle, `s_ready`=1, and the dropped op never issues.
- Assert `reset` asynchronously mid-stream between clock edges -> `o_valid`=0 and `s_ready`=1 immediately. After release, the first dispatch issues normally, with pointers wrapping correctly after 10 more ops.
